param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 32, number of words; SHALL be a power of two >=4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold in words.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold in words.
REQ-005 Parameter FWFT, default 0, read mode: 0 = standard (registered pop), 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 rd_en  input  1  read/pop request.
REQ-011 rd_data  output  WIDTH  read data.
REQ-012 rd_valid  output  1  rd_data holds a valid word.
REQ-013 empty, full, half_full, almost_empty, almost_full  output  1 each  status flags.
REQ-014 count  output  $clog2(DEPTH)+1  words currently stored, 0..DEPTH.
REQ-015 overflow, underflow, err_clr  output, output, input  1 each  sticky error flags and their clear (present only with FIFO_ERR_FLAGS_EN).

Function
REQ-016 Write accepted iff wr_en && !full; read accepted iff rd_en && !empty; flags are evaluated from the pre-edge state.
REQ-017 Pointers SHALL be $clog2(DEPTH)+1 bits wide with an extra wrap bit; addresses wrap from DEPTH-1 to 0 with no gap.
REQ-018 count: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-019 Full and write+read asserted: read accepted, write rejected, count becomes DEPTH-1.
REQ-020 Empty and write+read asserted: write accepted, read rejected, count becomes 1.
REQ-021 empty = (count==0); full = (count==DEPTH); half_full = (count>=DEPTH/2); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); all registered-state derived, no combinational path from wr_en/rd_en.
REQ-022 FWFT=0: accepted read at edge N drives rd_data with the head word and rd_valid=1 after edge N; rd_valid=0 and rd_data holds its last value in cycles with no accepted read; rd_data never driven to Z.
REQ-023 FWFT=1: rd_valid = !empty; rd_data shows the head word whenever rd_valid=1; accepted rd_en pops so the next word (or rd_valid=0) appears after the edge; first write into an empty FIFO becomes visible one cycle after its write edge.
REQ-024 Storage is never read out of order; data order SHALL equal write order across any number of pointer wraps.

Reset
REQ-025 reset=1 SHALL immediately force pointers=0, count=0, empty=1, almost_empty=1, full=half_full=almost_full=0, rd_valid=0, rd_data=0, overflow=underflow=0.
REQ-026 Storage array is not reset; reset mid-operation discards all contents and any in-flight read.
REQ-027 Requests in the first edge after reset deassertion are handled normally.

Configuration
REQ-028 Macro FIFO_ERR_FLAGS_EN: when defined, overflow sets on wr_en&&full, underflow sets on rd_en&&empty; both stay set until err_clr=1 at an edge (set wins over clear in the same cycle).
REQ-029 Without FIFO_ERR_FLAGS_EN the overflow, underflow and err_clr ports and their logic are absent; rejected requests are silently dropped.

Structure
REQ-030 Package param_fifo_pkg SHALL hold the pointer/count width function, the read-mode enum (MODE_STD, MODE_FWFT) and default parameter constants.
REQ-031 Storage SHALL be a separate sub-module fifo_mem (simple dual-port, one write port, one read port, WIDTH x DEPTH); control, flags and counters stay in param_fifo.

Verification
REQ-032 Reset, then write 0x0001..0x0020 (DEPTH=32) -> full=1 after 32nd write, count=32, 33rd write dropped; (macro) overflow=1.
REQ-033 Drain full FIFO with FWFT=0 -> rd_data 0x0001..0x0020 in order, rd_valid one cycle after each rd_en, empty=1 after last read.
REQ-034 100 mixed write/read words with 3 wraps, FWFT=1 -> output order matches input, rd_data valid with no pop latency.
REQ-035 count=32 with wr_en=rd_en=1 -> count=31, head popped, write dropped; count=0 with both -> count=1, no rd_valid.
REQ-036 Thresholds: fill to 16 -> half_full=1; AF_LEVEL=30 at count 30 -> almost_full=1; count 2 -> almost_empty=1, count 3 -> 0.
REQ-037 Assert reset mid-stream at count=10 -> all outputs per REQ-025 within the same cycle; subsequent write 0xBEEF reads back 0xBEEF.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// Shared types, defaults and width helper for the parameterised FIFO.
package param_fifo_pkg;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } read_mode_e;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_DEPTH    = 32;
    localparam int unsigned DEF_AE_LEVEL = 2;
    localparam int unsigned DEF_FWFT     = 0;

    // Pointer/count width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port WIDTH x DEPTH storage: synchronous write, asynchronous read.
module fifo_mem
    import param_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW   = ptr_width(DEPTH) - 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with status flags and standard or first-word-fall-through read.
// Optional sticky overflow/underflow flags are enabled with FIFO_ERR_FLAGS_EN.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
    parameter int unsigned FWFT     = DEF_FWFT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          half_full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [ptr_width(DEPTH)-1:0]   count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                          err_clr,
    output logic                          overflow,
    output logic                          underflow
`endif
);

    localparam int unsigned CW      = ptr_width(DEPTH);
    localparam int unsigned AW      = CW - 1;
    localparam bit          IS_FWFT = (FWFT == 32'(MODE_FWFT));

    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    rd_ptr_n;
    logic [CW-1:0]    count_n;
    logic             wr_acc;
    logic             rd_acc;
    logic [AW-1:0]    mem_rd_addr;
    logic [WIDTH-1:0] mem_rd_data_c;

    // Acceptance and next-state, all from pre-edge registered state.
    always_comb begin
        wr_acc   = wr_en && !full;
        rd_acc   = rd_en && !empty;
        count_n  = count;
        rd_ptr_n = rd_ptr;
        if (wr_acc && !rd_acc) begin
            count_n = count + CW'(1);
        end else if (!wr_acc && rd_acc) begin
            count_n = count - CW'(1);
        end
        if (rd_acc) begin
            rd_ptr_n = rd_ptr + CW'(1);
        end
    end

    // FWFT prefetches the word that will be the head after this edge.
    assign mem_rd_addr = IS_FWFT ? rd_ptr_n[AW-1:0] : rd_ptr[AW-1:0];

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en     (wr_acc),
        .wr_addr   (wr_ptr[AW-1:0]),
        .wr_data   (wr_data),
        .rd_addr   (mem_rd_addr),
        .rd_data_c (mem_rd_data_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            half_full    <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            rd_ptr       <= rd_ptr_n;
            count        <= count_n;
            empty        <= (count_n == '0);
            full         <= (count_n == CW'(DEPTH));
            half_full    <= (count_n >= CW'(DEPTH / 2));
            almost_empty <= (count_n <= CW'(AE_LEVEL));
            almost_full  <= (count_n >= CW'(AF_LEVEL));
            if (IS_FWFT) begin
                rd_valid <= (count_n != '0);
                // A word written this edge into an otherwise empty FIFO bypasses storage.
                if (wr_acc && (count_n == CW'(1))) begin
                    rd_data <= wr_data;
                end else if (count_n != '0) begin
                    rd_data <= mem_rd_data_c;
                end
            end else begin
                rd_valid <= rd_acc;
                if (rd_acc) begin
                    rd_data <= mem_rd_data_c;
                end
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en && full)  || (overflow  && !err_clr);
            underflow <= (rd_en && empty) || (underflow && !err_clr);
        end
    end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: one standard-read and one FWFT instance.
module tb_param_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        s_wr_en, s_rd_en, f_wr_en, f_rd_en;
    logic [15:0] s_wr_data, s_rd_data, f_wr_data, f_rd_data;
    logic        s_rd_valid, s_empty, s_full, s_half_full, s_almost_empty, s_almost_full;
    logic        f_rd_valid, f_empty, f_full, f_half_full, f_almost_empty, f_almost_full;
    logic [5:0]  s_count, f_count;
`ifdef FIFO_ERR_FLAGS_EN
    logic        err_clr;
    logic        s_overflow, s_underflow, f_overflow, f_underflow;
    logic        s_ovf_m, s_unf_m;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] s_q[$];
    logic [15:0] f_q[$];
    int          s_cnt, f_cnt, f_wrote, f_popped;
    logic [15:0] s_last;

    param_fifo #(.WIDTH(16), .DEPTH(32), .AF_LEVEL(30), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty), .full(s_full),
        .half_full(s_half_full), .almost_empty(s_almost_empty), .almost_full(s_almost_full),
        .count(s_count)
`ifdef FIFO_ERR_FLAGS_EN
        , .err_clr(err_clr), .overflow(s_overflow), .underflow(s_underflow)
`endif
    );

    param_fifo #(.WIDTH(16), .DEPTH(32), .AF_LEVEL(30), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty), .full(f_full),
        .half_full(f_half_full), .almost_empty(f_almost_empty), .almost_full(f_almost_full),
        .count(f_count)
`ifdef FIFO_ERR_FLAGS_EN
        , .err_clr(err_clr), .overflow(f_overflow), .underflow(f_underflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {empty, full, half_full, almost_empty, almost_full} for DEPTH=32, AF=30, AE=2.
    function automatic logic [4:0] flags_exp(input int c);
        return {c == 0, c == 32, c >= 16, c <= 2, c >= 30};
    endfunction

    task automatic std_cycle(input logic we, input logic [15:0] wd, input logic re);
        logic wacc, racc;
        logic [15:0] exp_word;
        s_wr_en = we; s_wr_data = wd; s_rd_en = re;
        wacc = we && (s_cnt != 32);
        racc = re && (s_cnt != 0);
`ifdef FIFO_ERR_FLAGS_EN
        s_ovf_m = (we && s_cnt == 32) || (s_ovf_m && !err_clr);
        s_unf_m = (re && s_cnt == 0)  || (s_unf_m && !err_clr);
`endif
        @(posedge clk); #1;
        if (wacc && !racc) s_cnt++;
        else if (racc && !wacc) s_cnt--;
        check("s_rd_valid", 32'(s_rd_valid), 32'(racc));
        if (s_rd_valid) begin
            if (s_q.size() == 0) begin
                check("s_sb_nonempty", 32'(s_q.size()), 32'd1);
            end else begin
                exp_word = s_q.pop_front();
                s_last   = exp_word;
                check("s_rd_data", 32'(s_rd_data), 32'(exp_word));
            end
        end else begin
            check("s_rd_hold", 32'(s_rd_data), 32'(s_last));
        end
        if (wacc) s_q.push_back(wd);
        check("s_count", 32'(s_count), 32'(s_cnt));
        check("s_flags", 32'({s_empty, s_full, s_half_full, s_almost_empty, s_almost_full}),
              32'(flags_exp(s_cnt)));
`ifdef FIFO_ERR_FLAGS_EN
        check("s_overflow", 32'(s_overflow), 32'(s_ovf_m));
        check("s_underflow", 32'(s_underflow), 32'(s_unf_m));
`endif
        s_wr_en = 1'b0; s_rd_en = 1'b0;
    endtask

    task automatic fwft_cycle(input logic we, input logic [15:0] wd, input logic re);
        logic wacc, racc;
        logic [15:0] dropped;
        f_wr_en = we; f_wr_data = wd; f_rd_en = re;
        wacc = we && (f_cnt != 32);
        racc = re && (f_cnt != 0);
        @(posedge clk); #1;
        if (racc) begin
            dropped = f_q.pop_front();
            f_popped++;
        end
        if (wacc) begin
            f_q.push_back(wd);
            f_wrote++;
        end
        if (wacc && !racc) f_cnt++;
        else if (racc && !wacc) f_cnt--;
        check("f_rd_valid", 32'(f_rd_valid), 32'(f_cnt != 0));
        if (f_cnt != 0) check("f_head", 32'(f_rd_data), 32'(f_q[0]));
        check("f_count", 32'(f_count), 32'(f_cnt));
        check("f_flags", 32'({f_empty, f_full, f_half_full, f_almost_empty, f_almost_full}),
              32'(flags_exp(f_cnt)));
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_s_count"}, 32'(s_count), 32'd0);
        check({tag, "_s_flags"}, 32'({s_empty, s_full, s_half_full, s_almost_empty, s_almost_full}),
              32'(5'b10010));
        check({tag, "_s_rd_valid"}, 32'(s_rd_valid), 32'd0);
        check({tag, "_s_rd_data"}, 32'(s_rd_data), 32'd0);
        check({tag, "_f_count"}, 32'(f_count), 32'd0);
        check({tag, "_f_rd_valid"}, 32'(f_rd_valid), 32'd0);
        check({tag, "_f_rd_data"}, 32'(f_rd_data), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        check({tag, "_s_overflow"}, 32'(s_overflow), 32'd0);
        check({tag, "_s_underflow"}, 32'(s_underflow), 32'd0);
`endif
    endtask

    task automatic clear_models();
        s_q.delete(); f_q.delete();
        s_cnt = 0; f_cnt = 0; s_last = '0;
`ifdef FIFO_ERR_FLAGS_EN
        s_ovf_m = 1'b0; s_unf_m = 1'b0;
`endif
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
        f_wrote = 0; f_popped = 0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;

        // Fill to full, then one dropped write.
        for (int i = 1; i <= 33; i++) std_cycle(1'b1, 16'(i), 1'b0);
        check("s_full_after_fill", 32'(s_full), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b1;
        std_cycle(1'b0, 16'h0, 1'b0);
        err_clr = 1'b0;
`endif
        // Drain in order, then one read on empty.
        for (int i = 0; i < 33; i++) std_cycle(1'b0, 16'h0, 1'b1);
        check("s_empty_after_drain", 32'(s_empty), 32'd1);

        // Simultaneous write+read on empty, refill, simultaneous on full.
        std_cycle(1'b1, 16'h5A5A, 1'b1);
        for (int i = 0; i < 31; i++) std_cycle(1'b1, 16'(16'h0100 + i), 1'b0);
        std_cycle(1'b1, 16'hAAAA, 1'b1);
        check("s_count_full_both", 32'(s_count), 32'd31);

        // Drain to 10 and reset mid-stream.
        while (s_cnt > 10) std_cycle(1'b0, 16'h0, 1'b1);
        reset = 1'b1;
        #2;
        check_reset_state("mid");
        clear_models();
        @(posedge clk); #1;
        reset = 1'b0;
        std_cycle(1'b1, 16'hBEEF, 1'b0);
        std_cycle(1'b0, 16'h0, 1'b1);
        check("s_beef", 32'(s_rd_data), 32'h0000BEEF);

        // FWFT: 100 words with random interleaving across several wraps.
        cyc = 0;
        while ((f_wrote < 100 || f_cnt != 0) && cyc < 3000) begin
            fwft_cycle((f_wrote < 100) && ($urandom_range(3) != 0),
                       16'(16'h1000 + f_wrote), $urandom_range(2) == 0);
            cyc++;
        end
        check("f_done_in_budget", 32'(cyc < 3000), 32'd1);
        check("f_popped", 32'(f_popped), 32'd100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
